pipelined_adder: RTL and testbench

// - Parametrised, pipelined ripple-carry adder: successor to the gate-level

---
 rtl/pipelined_adder.sv | 134 +++++++++++++
 tb/tb_pipelined_adder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES chunks, one
// chunk added per stage with the carry registered between stages. Operands
// ride along through skew registers and finished low chunks are carried
// forward so every sum bit leaves the last stage together. Valid/ready
// handshake on both ends; a stalled output freezes the whole pipeline.

module pipelined_adder_stage #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_carry,
  output logic             dn_vld,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b,
  output logic [WIDTH-1:0] dn_sum,
  output logic             dn_carry,
  output logic             dn_ovf
);
  localparam int LO = K * CHUNK;
  localparam int HI = LO + CHUNK - 1;

  logic [CHUNK:0]   add;
  logic [WIDTH-1:0] next_sum;
  logic             msb_cin;

  assign add = {1'b0, up_a[LO +: CHUNK]} + {1'b0, up_b[LO +: CHUNK]}
             + {{CHUNK{1'b0}}, up_carry};
  // Carry into the top bit of this chunk, recovered from the chunk's sum bit.
  assign msb_cin = up_a[HI] ^ up_b[HI] ^ add[CHUNK-1];

  // Splice this stage's chunk result into the partial sum travelling down.
  always_comb begin
    next_sum = up_sum;
    next_sum[LO +: CHUNK] = add[CHUNK-1:0];
  end

  // Stage register: valid always advances when enabled; data only loads for
  // a real operation so outputs hold their last value across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_vld   <= 1'b0;
      dn_a     <= '0;
      dn_b     <= '0;
      dn_sum   <= '0;
      dn_carry <= 1'b0;
      dn_ovf   <= 1'b0;
    end else if (en) begin
      dn_vld <= up_vld;
      if (up_vld) begin
        dn_a     <= up_a;
        dn_b     <= up_b;
        dn_sum   <= next_sum;
        dn_carry <= add[CHUNK];
        dn_ovf   <= msb_cin ^ add[CHUNK];
      end
    end
  end
endmodule

module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: need WIDTH >= 1, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
  end

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] a_pipe, b_pipe, s_pipe;
  logic [STAGES:0]            c_pipe, ovf_pipe;
  logic                       stall;
  logic                       unused_bits;

  // A held output freezes everything upstream, including skew and carries.
  assign stall    = vld_pipe[STAGES] && !out_ready;
  assign in_ready = rst_n && !stall;

  assign vld_pipe[0] = in_valid && in_ready;
  assign a_pipe[0]   = a;
  assign b_pipe[0]   = b;
  assign s_pipe[0]   = '0;
  assign c_pipe[0]   = cin;
  assign ovf_pipe[0] = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .K(k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (!stall),
      .up_vld   (vld_pipe[k]),
      .up_a     (a_pipe[k]),
      .up_b     (b_pipe[k]),
      .up_sum   (s_pipe[k]),
      .up_carry (c_pipe[k]),
      .dn_vld   (vld_pipe[k+1]),
      .dn_a     (a_pipe[k+1]),
      .dn_b     (b_pipe[k+1]),
      .dn_sum   (s_pipe[k+1]),
      .dn_carry (c_pipe[k+1]),
      .dn_ovf   (ovf_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = s_pipe[STAGES];
  assign cout      = c_pipe[STAGES];
  assign ovf       = ovf_pipe[STAGES];

  // Operand skew past the last stage and early-stage overflow are dead ends.
  assign unused_bits = ^{a_pipe[STAGES], b_pipe[STAGES], ovf_pipe[STAGES-1:0]};
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 8-bit/4-stage main instance with
// directed, back-to-back, backpressure and reset scenarios, plus 16-bit
// instances at 1 and 16 stages fed a shared random stream.
module tb_pipelined_adder;
  localparam int W = 8;
  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    int          st;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_chk = 0, n_err = 0, cyc = 0, stall_cnt = 0;
  logic prev_rst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout, signed range for ovf.
  function automatic exp_t model(input int w, input longint x, input longint y,
                                 input int c, input int t, input int s);
    exp_t   e;
    longint m   = longint'(1) << w;
    longint tot = x + y + c;
    longint sx  = (x >= m / 2) ? x - m : x;
    longint sy  = (y >= m / 2) ? y - m : y;
    longint sr  = sx + sy + c;
    e.sum  = 16'(tot % m);
    e.cout = (tot >= m);
    e.ovf  = (sr >= m / 2) || (sr < -(m / 2));
    e.cyc  = t;
    e.st   = s;
    return e;
  endfunction

  // Main monitor: samples on the falling edge, pushes accepted ops and pops results.
  always @(negedge clk) begin
    exp_t e;
    chk("in_ready_rule", in_ready, rst_n && !(out_valid && !out_ready));
    if (!prev_rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
    end
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = q[0];
          chk("sum", sum, e.sum[W-1:0]);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
          if (out_ready) begin
            chk("latency", cyc - e.cyc, S + stall_cnt - e.st);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(W, a, b, cin, cyc, stall_cnt));
        n_vec++;
      end
      if (out_valid && !out_ready) stall_cnt++;
    end
    prev_rst = rst_n;
  end

  // 16-bit instances at both extremes of stage count; consumer always ready.
  logic        v16, c16;
  logic [15:0] a16, b16;

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int ST = (g == 0) ? 1 : 16;
    logic        rdy, ov, co, of;
    logic [15:0] sm;
    exp_t        q16[$];

    pipelined_adder #(.WIDTH(16), .STAGES(ST)) u_wide (
      .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy),
      .a(a16), .b(b16), .cin(c16), .out_valid(ov), .out_ready(1'b1),
      .sum(sm), .cout(co), .ovf(of)
    );

    always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
        q16.delete();
      end else begin
        if (ov) begin
          if (q16.size() == 0) begin
            chk($sformatf("spurious_out_w16s%0d", ST), ov, 0);
          end else begin
            e = q16.pop_front();
            chk($sformatf("sum_w16s%0d", ST), sm, e.sum);
            chk($sformatf("cout_w16s%0d", ST), co, e.cout);
            chk($sformatf("ovf_w16s%0d", ST), of, e.ovf);
            chk($sformatf("latency_w16s%0d", ST), cyc - e.cyc, ST);
          end
        end
        if (v16 && rdy) begin
          q16.push_back(model(16, a16, b16, c16, cyc, 0));
          n_vec++;
        end
      end
    end
  end

  // Called at posedge+1; holds the op until accepted, returns at posedge+1.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int k = 0;
    in_valid = 1'b1; a = x; b = y; cin = c;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rand();
    send(8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  bit done;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0; done = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Carry-chain and overflow corners.
    send(8'hFF, 8'h01, 1'b0);
    send(8'h7F, 8'h01, 1'b0);
    send(8'h80, 8'h80, 1'b1);
    idle(6);

    // Full-throughput stream.
    repeat (256) send_rand();
    idle(8);

    // Three ops in flight, consumer stalled long enough to back up.
    out_ready = 1'b0;
    repeat (3) send_rand();
    idle(8);
    out_ready = 1'b1;
    idle(6);

    // Reset with three ops in flight: none of them may ever appear.
    repeat (3) send_rand();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(10);

    // Random bubbles against random backpressure.
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    idle(10);

    // Wide configurations, including all-ones carry-chain patterns.
    for (int i = 0; i < 200; i++) begin
      v16 = ($urandom_range(0, 3) != 0);
      case (i % 4)
        0:       begin a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1; end
        1:       begin a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0; end
        default: begin a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom); end
      endcase
      idle(1);
    end
    v16 = 1'b0;
    idle(20);

    chk("drain_w8", q.size(), 0);
    chk("drain_w16s1", g_cfg[0].q16.size(), 0);
    chk("drain_w16s16", g_cfg[1].q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
